vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vid_timing_pkg.sv | 27 ++
 rtl/vid_axis_counter.sv | 29 ++
 rtl/vga_timing_gen.sv | 108 ++++++++++
 tb/tb_vga_timing_gen.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/vid_timing_pkg.sv
// Default 640x480@60 video timing constants and the helpers that derive
// line/frame totals and sync window edges from the porch/sync widths.
package vid_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 29;

    function automatic int f_total(input int act, input int fp, input int sw, input int bp);
        return act + fp + sw + bp;
    endfunction

    function automatic int f_sync_start(input int act, input int fp);
        return act + fp;
    endfunction

    // Inclusive last position of the sync window.
    function automatic int f_sync_end(input int act, input int fp, input int sw);
        return act + fp + sw - 1;
    endfunction

endpackage

// File: rtl/vid_axis_counter.sv
// Modulo-MOD position counter with an enable and a combinational wrap pulse,
// used for both the horizontal and vertical axes.
module vid_axis_counter #(
    parameter int MOD = 800,
    parameter int CW  = 10
) (
    input  logic          clk25,
    input  logic          rst,
    input  logic          i_en,
    output logic [CW-1:0] o_cnt,
    output logic          o_wrap
);

    localparam logic [CW-1:0] LAST = CW'(MOD - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk25) begin
        if (rst)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end

    // High on the enabled clock that takes the counter from LAST back to 0.
    assign o_wrap = i_en && (r_cnt == LAST);
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters plus one registered decode stage, so every
// output lags the counters by one enabled clock and all outputs stay aligned.
module vga_timing_gen
    import vid_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 10
) (
    input  logic          clk25,
    input  logic          rst,
    input  logic          en,
    output logic          hsyncOut,
    output logic          vsyncOut,
    output logic          deOut,
    output logic [CW-1:0] xposOut,
    output logic [CW-1:0] yposOut,
    output logic          lineStartOut,
    output logic          frameStartOut,
    output logic [7:0]    frameCntOut
);

    localparam int H_TOTAL = f_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = f_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CW-1:0] HS_START = CW'(f_sync_start(H_ACTIVE, H_FP));
    localparam logic [CW-1:0] HS_END   = CW'(f_sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [CW-1:0] VS_START = CW'(f_sync_start(V_ACTIVE, V_FP));
    localparam logic [CW-1:0] VS_END   = CW'(f_sync_end(V_ACTIVE, V_FP, V_SYNC));
    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);

    logic [CW-1:0] w_hc, w_vc;
    logic          w_h_wrap, w_v_wrap;

    vid_axis_counter #(.MOD(H_TOTAL), .CW(CW)) u_hcnt (
        .clk25  (clk25),
        .rst    (rst),
        .i_en   (en),
        .o_cnt  (w_hc),
        .o_wrap (w_h_wrap)
    );

    // Vertical axis steps only on the horizontal wrap, so end-of-line and
    // end-of-frame resolve in the same clock.
    vid_axis_counter #(.MOD(V_TOTAL), .CW(CW)) u_vcnt (
        .clk25  (clk25),
        .rst    (rst),
        .i_en   (w_h_wrap),
        .o_cnt  (w_vc),
        .o_wrap (w_v_wrap)
    );

    logic          w_hs_act, w_vs_act, w_de;
    logic          r_hsync, r_vsync, r_de, r_line, r_frame;
    logic [CW-1:0] r_x, r_y;
    logic [7:0]    r_frame_cnt;

    assign w_hs_act = (w_hc >= HS_START) && (w_hc <= HS_END);
    assign w_vs_act = (w_vc >= VS_START) && (w_vc <= VS_END);
    assign w_de     = (w_hc < H_ACT_C) && (w_vc < V_ACT_C);

    always_ff @(posedge clk25) begin
        if (rst) begin
            r_hsync     <= ~HS_POL;
            r_vsync     <= ~VS_POL;
            r_de        <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_line      <= 1'b0;
            r_frame     <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            // Pulses drop on any idle clock; level outputs simply hold.
            r_line  <= 1'b0;
            r_frame <= 1'b0;
            if (en) begin
                r_hsync <= w_hs_act ? HS_POL : ~HS_POL;
                r_vsync <= w_vs_act ? VS_POL : ~VS_POL;
                r_de    <= w_de;
                r_x     <= w_hc;
                r_y     <= w_vc;
                r_line  <= (w_hc == '0);
                r_frame <= (w_hc == '0) && (w_vc == '0);
            end
            if (w_v_wrap)
                r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign hsyncOut      = r_hsync;
    assign vsyncOut      = r_vsync;
    assign deOut         = r_de;
    assign xposOut       = r_x;
    assign yposOut       = r_y;
    assign lineStartOut  = r_line;
    assign frameStartOut = r_frame;
    assign frameCntOut   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing line checks plus a tiny 8x6 raster for
// frame layout, enable gating, mid-frame reset and frame-counter wrap.
module tb_vga_timing_gen;

    logic clk25 = 1'b0;
    logic rst, en;
    always #5 clk25 = ~clk25;

    logic       d_hs, d_vs, d_de, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic [7:0] d_fc;

    logic       s_hs, s_vs, s_de, s_ls, s_fs;
    logic [3:0] s_x, s_y;
    logic [7:0] s_fc;

    vga_timing_gen u_def (
        .clk25(clk25), .rst(rst), .en(en),
        .hsyncOut(d_hs), .vsyncOut(d_vs), .deOut(d_de),
        .xposOut(d_x), .yposOut(d_y),
        .lineStartOut(d_ls), .frameStartOut(d_fs), .frameCntOut(d_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(4)
    ) u_dut (
        .clk25(clk25), .rst(rst), .en(en),
        .hsyncOut(s_hs), .vsyncOut(s_vs), .deOut(s_de),
        .xposOut(s_x), .yposOut(s_y),
        .lineStartOut(s_ls), .frameStartOut(s_fs), .frameCntOut(s_fc)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk25);
        #1;
    endtask

    // Small raster, indexed by x: hsync high at x=5..6, active at x=0..3.
    logic [7:0] hs_tab = 8'h60;
    logic [7:0] de_tab = 8'h0f;

    initial begin
        int lo, first, last, dec, nfs;
        bit found;
        rst = 1'b1;
        en  = 1'b0;
        tick();
        tick();
        chk("rst_hs", s_hs, 0);
        chk("rst_vs", s_vs, 0);
        chk("rst_de", s_de, 0);
        chk("rst_x", s_x, 0);
        chk("rst_y", s_y, 0);
        chk("rst_ls", s_ls, 0);
        chk("rst_fs", s_fs, 0);
        chk("rst_fc", s_fc, 0);
        chk("rst_def_hs", d_hs, 1);
        chk("rst_def_vs", d_vs, 1);

        // One full default line.
        rst = 1'b0;
        en  = 1'b1;
        lo = 0; first = -1; last = -1; dec = 0;
        for (int i = 0; i < 800; i++) begin
            tick();
            if (i == 0) begin
                chk("def_first_x", d_x, 0);
                chk("def_first_fs", d_fs, 1);
                chk("def_first_de", d_de, 1);
            end
            if (d_hs == 1'b0) begin
                lo++;
                if (first < 0) first = int'(d_x);
                last = int'(d_x);
            end
            if (d_de) dec++;
        end
        chk("def_hs_low_cnt", lo, 96);
        chk("def_hs_first", first, 656);
        chk("def_hs_last", last, 751);
        chk("def_de_cnt", dec, 640);
        chk("def_vs_line0", d_vs, 1);
        tick();
        chk("def_l1_x", d_x, 0);
        chk("def_l1_y", d_y, 1);
        chk("def_l1_ls", d_ls, 1);
        chk("def_l1_fs", d_fs, 0);

        // Small raster: one full frame straight after reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int y = 0; y < 6; y++) begin
            for (int x = 0; x < 8; x++) begin
                tick();
                chk("fr_x", s_x, x);
                chk("fr_y", s_y, y);
                chk("fr_hs", s_hs, hs_tab[x]);
                chk("fr_vs", s_vs, (y == 4));
                chk("fr_de", s_de, de_tab[x] && (y < 3));
                chk("fr_ls", s_ls, (x == 0));
                chk("fr_fs", s_fs, (x == 0) && (y == 0));
                chk("fr_fc", s_fc, (x == 7) && (y == 5));
            end
        end

        // Enable one clock in four: levels hold, pulses last one clock.
        for (int k = 0; k < 8; k++) begin
            en = 1'b1;
            tick();
            chk("en_x", s_x, k);
            chk("en_y", s_y, 0);
            chk("en_ls", s_ls, (k == 0));
            chk("en_fs", s_fs, (k == 0));
            en = 1'b0;
            for (int j = 0; j < 3; j++) begin
                tick();
                chk("hold_x", s_x, k);
                chk("hold_hs", s_hs, hs_tab[k]);
                chk("hold_de", s_de, de_tab[k]);
                chk("hold_ls", s_ls, 0);
                chk("hold_fs", s_fs, 0);
            end
        end

        // Reset in the middle of the frame.
        en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (s_x == 4'd3 && s_y == 4'd2) found = 1'b1;
        end
        chk("mid_reached", found, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_x", s_x, 0);
        chk("mid_rst_de", s_de, 0);
        chk("mid_rst_fs", s_fs, 0);
        rst = 1'b0;
        tick();
        chk("mid_post_x", s_x, 0);
        chk("mid_post_y", s_y, 0);
        chk("mid_post_de", s_de, 1);
        chk("mid_post_fs", s_fs, 1);
        chk("mid_post_fc", s_fc, 0);

        // 256 frames of 48 clocks: counter wraps 255 -> 0.
        nfs = 0;
        for (int i = 0; i < 48 * 255; i++) begin
            tick();
            if (s_fs) nfs++;
        end
        chk("wrap_fs_cnt", nfs, 255);
        chk("wrap_fc255", s_fc, 255);
        chk("wrap_x0", s_x, 0);
        chk("wrap_y0", s_y, 0);
        for (int i = 0; i < 47; i++) tick();
        chk("wrap_last_x", s_x, 7);
        chk("wrap_last_y", s_y, 5);
        chk("wrap_fc0", s_fc, 0);
        tick();
        chk("wrap_next_fs", s_fs, 1);
        chk("wrap_next_fc", s_fc, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
